timing_counter: RTL and testbench

//  Free-running horizontal/vertical raster counter for the video pipeline.
//  - Produces hcount/vcount, which feed the sync_gen comparators (HSYNC/VSYNC) and the pixel renderers.
//  - Also produces registered blanking/data-enable flags and one-cycle line/frame start pulses.
//  - Advances only on pixel clock-enable, so one fast system clock can drive several pixel rates.

---
 rtl/timing_counter.sv | 142 ++++++++++++++
 tb/tb_timing_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timing_counter.sv
// timing_counter: free-running horizontal/vertical raster counter.
//
// Produces the pixel column/line position for the sync generator and the
// renderers, and the blanking/data-enable flags that go with it. It also
// produces one-clock line and frame start pulses. Everything advances only
// on cycles where pix_ce is high.
//
// Optional feature: define TIMING_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_cnt). It increments on the same edge that raises frame_start.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous reset, active-low (priority over pix_ce)
//   pix_ce       in   pixel clock-enable
//   hcount       out  current pixel column, 0..H_TOTAL-1
//   vcount       out  current line, 0..V_TOTAL-1
//   hblank       out  hcount >= H_ACTIVE
//   vblank       out  vcount >= V_ACTIVE
//   de           out  !hblank && !vblank
//   line_start   out  one-clock pulse on the ce-cycle entering hcount==0
//   frame_start  out  one-clock pulse on the ce-cycle entering (0,0)
//   frame_cnt    out  completed-frame counter (TIMING_FRAME_CNT_EN only)
module timing_counter #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_TOTAL  = 1344,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_TOTAL  = 806,
    parameter int unsigned WIDTH    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
    output logic [WIDTH-1:0] hcount,
    output logic [WIDTH-1:0] vcount,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
`ifdef TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam longint unsigned COUNT_CAP = 64'(1) << WIDTH;

    // Reject timing parameters the counters cannot represent.
    if (H_TOTAL <= H_ACTIVE) begin : g_bad_h_total
        $error("timing_counter: H_TOTAL must exceed H_ACTIVE");
    end
    if (V_TOTAL <= V_ACTIVE) begin : g_bad_v_total
        $error("timing_counter: V_TOTAL must exceed V_ACTIVE");
    end
    if (64'(H_TOTAL) > COUNT_CAP || 64'(V_TOTAL) > COUNT_CAP) begin : g_bad_width
        $error("timing_counter: WIDTH too small for H_TOTAL/V_TOTAL");
    end

    localparam logic [WIDTH-1:0] H_LAST  = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_LAST  = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] H_BLANK = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] V_BLANK = WIDTH'(V_ACTIVE);

    logic [WIDTH-1:0] r_hcount;
    logic [WIDTH-1:0] r_vcount;
    logic             r_hblank;
    logic             r_vblank;
    logic             r_de;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [WIDTH-1:0] w_hcount_nxt;
    logic [WIDTH-1:0] w_vcount_nxt;
    logic             w_hblank_nxt;
    logic             w_vblank_nxt;

    // Next position. Wrap is explicit at TOTAL-1, never by counter overflow.
    always_comb begin
        w_h_wrap     = (r_hcount == H_LAST);
        w_v_wrap     = (r_vcount == V_LAST);
        w_hcount_nxt = r_hcount + WIDTH'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = w_v_wrap ? '0 : (r_vcount + WIDTH'(1));
        end
        // Flags come from the next position so they line up with the counters.
        w_hblank_nxt = (w_hcount_nxt >= H_BLANK);
        w_vblank_nxt = (w_vcount_nxt >= V_BLANK);
    end

    // Counters, flags and start pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_de          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_ce) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblank      <= w_hblank_nxt;
            r_vblank      <= w_vblank_nxt;
            r_de          <= !w_hblank_nxt && !w_vblank_nxt;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end else begin
            // Pulses are one clock wide even when pix_ce is sparse.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Counts frame_start events; wraps naturally from 16'hFFFF to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (pix_ce && w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_timing_counter.sv
// Directed testbench for timing_counter: default 1344x806 instance plus a
// small 8x4 instance for frame-level behaviour.
module tb_timing_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default-parameter instance.
    logic        rst_n_d;
    logic        ce_d;
    logic [10:0] hc_d;
    logic [10:0] vc_d;
    logic        hb_d, vb_d, de_d, ls_d, fs_d;
`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] fc_d;
`endif

    timing_counter u_dflt (
        .clk         (clk),
        .rst_n       (rst_n_d),
        .pix_ce      (ce_d),
        .hcount      (hc_d),
        .vcount      (vc_d),
        .hblank      (hb_d),
        .vblank      (vb_d),
        .de          (de_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
`ifdef TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_d)
`endif
    );

    // Small instance: 8 x 4 total, 6 x 3 active.
    logic       rst_n_s;
    logic       ce_s;
    logic [3:0] hc_s;
    logic [3:0] vc_s;
    logic       hb_s, vb_s, de_s, ls_s, fs_s;
`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] fc_s;
`endif

    timing_counter #(
        .H_ACTIVE (6),
        .H_TOTAL  (8),
        .V_ACTIVE (3),
        .V_TOTAL  (4),
        .WIDTH    (4)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n_s),
        .pix_ce      (ce_s),
        .hcount      (hc_s),
        .vcount      (vc_s),
        .hblank      (hb_s),
        .vblank      (vb_s),
        .de          (de_s),
        .line_start  (ls_s),
        .frame_start (fs_s)
`ifdef TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_s)
`endif
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int fs_seen;
    int fs_pos;

    initial begin
        rst_n_d = 1'b0; ce_d = 1'b1;
        rst_n_s = 1'b0; ce_s = 1'b1;

        // Reset held 3 clocks with pix_ce high.
        tick(3);
        check_val("rst_h",  int'(hc_d), 0);
        check_val("rst_v",  int'(vc_d), 0);
        check_val("rst_de", int'(de_d), 1);
        check_val("rst_hb", int'(hb_d), 0);
        check_val("rst_vb", int'(vb_d), 0);
        check_val("rst_ls", int'(ls_d), 0);
        check_val("rst_fs", int'(fs_d), 0);

        // Line wrap on default instance.
        rst_n_d = 1'b1;
        tick(1023);
        check_val("h1023",    int'(hc_d), 1023);
        check_val("h1023_hb", int'(hb_d), 0);
        check_val("h1023_de", int'(de_d), 1);
        tick(1);
        check_val("h1024",    int'(hc_d), 1024);
        check_val("h1024_hb", int'(hb_d), 1);
        check_val("h1024_de", int'(de_d), 0);
        tick(319);
        check_val("h1343",    int'(hc_d), 1343);
        check_val("h1343_ls", int'(ls_d), 0);
        check_val("h1343_v",  int'(vc_d), 0);
        tick(1);
        check_val("wrap_h",  int'(hc_d), 0);
        check_val("wrap_v",  int'(vc_d), 1);
        check_val("wrap_ls", int'(ls_d), 1);
        check_val("wrap_fs", int'(fs_d), 0);
        check_val("wrap_de", int'(de_d), 1);
        tick(1);
        check_val("post_h",  int'(hc_d), 1);
        check_val("post_ls", int'(ls_d), 0);

        // Mid-frame reset at (500,1).
        tick(499);
        check_val("pre_rst_h", int'(hc_d), 500);
        rst_n_d = 1'b0;
        tick(1);
        rst_n_d = 1'b1;
        check_val("mrst_h",  int'(hc_d), 0);
        check_val("mrst_v",  int'(vc_d), 0);
        check_val("mrst_fs", int'(fs_d), 0);
        check_val("mrst_ls", int'(ls_d), 0);
        check_val("mrst_de", int'(de_d), 1);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check_val("resume_h", int'(hc_d), i);
        end

        // CE gating 1,0,1,0 on default instance.
        ce_d = 1'b1; tick(1); check_val("ce1_h", int'(hc_d), 4);
        ce_d = 1'b0; tick(1); check_val("ce0_h", int'(hc_d), 4);
        ce_d = 1'b1; tick(1); check_val("ce1b_h", int'(hc_d), 5);
        ce_d = 1'b0; tick(1); check_val("ce0b_h", int'(hc_d), 5);

        // Small instance: pulse width under CE gating.
        rst_n_s = 1'b1;
        tick(7);
        check_val("s_h7",    int'(hc_s), 7);
        check_val("s_h7_hb", int'(hb_s), 1);
        tick(1);
        check_val("s_wrap_h",  int'(hc_s), 0);
        check_val("s_wrap_v",  int'(vc_s), 1);
        check_val("s_wrap_ls", int'(ls_s), 1);
        ce_s = 1'b0; tick(1);
        check_val("s_gate_ls", int'(ls_s), 0);
        check_val("s_gate_h",  int'(hc_s), 0);
        tick(1);
        check_val("s_gate2_ls", int'(ls_s), 0);
        ce_s = 1'b1; tick(1);
        check_val("s_resume_h",  int'(hc_s), 1);
        check_val("s_resume_ls", int'(ls_s), 0);

        // Small instance: frame wrap and period.
        rst_n_s = 1'b0; tick(1); rst_n_s = 1'b1;
        tick(31);
        check_val("s_73_h",  int'(hc_s), 7);
        check_val("s_73_v",  int'(vc_s), 3);
        check_val("s_73_vb", int'(vb_s), 1);
        check_val("s_73_de", int'(de_s), 0);
        check_val("s_73_fs", int'(fs_s), 0);
        tick(1);
        check_val("s_fw_h",  int'(hc_s), 0);
        check_val("s_fw_v",  int'(vc_s), 0);
        check_val("s_fw_fs", int'(fs_s), 1);
        check_val("s_fw_ls", int'(ls_s), 1);
        check_val("s_fw_de", int'(de_s), 1);
        fs_seen = 0; fs_pos = -1;
        for (int i = 1; i <= 32; i++) begin
            tick(1);
            if (fs_s) begin
                fs_seen++;
                fs_pos = i;
            end
        end
        check_val("s_period_cnt", fs_seen, 1);
        check_val("s_period_pos", fs_pos, 32);

`ifdef TIMING_FRAME_CNT_EN
        tick(32);
        check_val("s_fcnt3", int'(fc_s), 3);
        tick(3);
        force u_small.r_frame_cnt = 16'hFFFF;
        tick(1);
        release u_small.r_frame_cnt;
        check_val("s_fcnt_forced", int'(fc_s), 32'h0000FFFF);
        fs_seen = 0;
        for (int i = 0; i < 40 && fs_seen == 0; i++) begin
            tick(1);
            if (fs_s) fs_seen = 1;
        end
        check_val("s_fcnt_fs_seen", fs_seen, 1);
        check_val("s_fcnt_wrap", int'(fc_s), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
